// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline register slices.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_DW_DEFAULT = 32;

    // Encoding 2'd3 is illegal; the slice recovers from it to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_skid_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buf
//  Description : Two-entry valid/ready skid slice with registered in_ready,
//                one-cycle latency, full throughput and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DW = PIPE_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    pipe_skid_state_e r_state;
    logic [DW-1:0]    r_main;
    logic [DW-1:0]    r_skid;

    logic w_in_fire;
    logic w_out_fire;

    // Handshake outputs depend only on the state register: no in->out comb path.
    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
            r_main  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= ONE;
                        r_main  <= in_data;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main  <= in_data;
                    end else if (w_in_fire) begin
                        r_state <= FULL;
                        r_skid  <= in_data;
                    end else if (w_out_fire) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic          r_chk_hold;
    logic [DW-1:0] r_chk_data;

    always_ff @(posedge clk) begin
        r_chk_hold <= !rst && !flush && out_valid && !out_ready;
        r_chk_data <= out_data;
        if (!rst) begin
            assert (r_state inside {EMPTY, ONE, FULL});
            assert (in_ready || (r_state == FULL));
            if (r_chk_hold) begin
                assert (out_data == r_chk_data);
            end
        end
    end
`endif

endmodule : pipe_skid_buf
`default_nettype wire

// File: tb/tb_pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_buf
//  Description : Self-checking bench for pipe_skid_buf (vector table + FIFO
//                scoreboard under random handshakes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_skid_buf #(.DW(DW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        logic          rst;
        logic          flush;
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ov;
        logic          ir;
        logic [DW-1:0] od;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic [DW-1:0] id,
                       input logic ordy, input logic ov, input logic ir, input logic [DW-1:0] od);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.od = od;
        vecs.push_back(v);
    endtask

    // One random-phase cycle: drive at negedge, check against the scoreboard, update it.
    task automatic sb_cycle(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
        @(negedge clk);
        rst       = 1'b0;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        check("sb out_valid", DW'(out_valid), DW'(sb_q.size() != 0));
        check("sb in_ready", DW'(in_ready), DW'(sb_q.size() != 2));
        if (out_valid && out_ready && sb_q.size() != 0) begin
            check("sb out_data", out_data, sb_q[0]);
            void'(sb_q.pop_front());
        end
        if (fl) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            sb_q.push_back(in_data);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //   rst  fl  iv  data       ordy  ov  ir  out_data
        add(1, 0, 0, 32'h00, 0, 0, 1, 32'h00);   // reset
        add(0, 0, 0, 32'h00, 0, 0, 1, 32'h00);   // idle
        add(0, 0, 1, 32'h11, 1, 1, 1, 32'h11);   // stream
        add(0, 0, 1, 32'h22, 1, 1, 1, 32'h22);
        add(0, 0, 1, 32'h33, 1, 1, 1, 32'h33);
        add(0, 0, 0, 32'h00, 1, 0, 1, 32'h33);   // drained, last value shown
        add(0, 0, 1, 32'hA1, 0, 1, 1, 32'hA1);   // backpressure
        add(0, 0, 1, 32'hA2, 0, 1, 0, 32'hA1);
        add(0, 0, 1, 32'hA3, 0, 1, 0, 32'hA1);
        add(0, 0, 1, 32'hA3, 1, 1, 1, 32'hA2);
        add(0, 0, 1, 32'hA3, 1, 1, 1, 32'hA3);
        add(0, 0, 0, 32'h00, 1, 0, 1, 32'hA3);
        add(0, 0, 1, 32'h55, 0, 1, 1, 32'h55);   // flush while FULL
        add(0, 0, 1, 32'h66, 0, 1, 0, 32'h55);
        add(0, 1, 1, 32'hFF, 0, 0, 1, 32'h00);
        add(0, 0, 0, 32'h00, 1, 0, 1, 32'h00);
        add(0, 0, 1, 32'h77, 0, 1, 1, 32'h77);   // flush in ONE with both handshakes
        add(0, 1, 1, 32'h88, 1, 0, 1, 32'h00);
        add(0, 0, 0, 32'h00, 1, 0, 1, 32'h00);
        add(0, 0, 1, 32'h91, 0, 1, 1, 32'h91);   // reset mid-stall
        add(0, 0, 1, 32'h92, 0, 1, 0, 32'h91);
        add(1, 0, 1, 32'h93, 0, 0, 1, 32'h00);
        add(0, 0, 0, 32'h00, 0, 0, 1, 32'h00);
        add(0, 0, 1, 32'h94, 0, 1, 1, 32'h94);   // ONE hold, then rst+flush while FULL
        add(0, 0, 0, 32'h00, 0, 1, 1, 32'h94);
        add(0, 0, 1, 32'h95, 0, 1, 0, 32'h94);
        add(1, 1, 1, 32'h96, 0, 0, 1, 32'h00);
        add(0, 0, 0, 32'h00, 1, 0, 1, 32'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vecs[i].ov));
            check($sformatf("vec%0d in_ready", i), DW'(in_ready), DW'(vecs[i].ir));
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
        end

        for (int c = 0; c < 10000; c++) begin
            sb_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 199) == 0);
        end
        for (int c = 0; c < 4; c++) begin
            sb_cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain queue empty", DW'(sb_q.size()), '0);
        check("drain out_valid", DW'(out_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_skid_buf
`default_nettype wire
